multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle successor to the single-cycle control decoder. It sequences each MIPS instruction through fetch, decode, execute, memory and writeback states, so the datapath can share one ALU and one memory port. It drives the same control signal set (PCSrc, RegDst, MemtoReg, ALUFun, ExtOp, LuOp, Sign, …), adds per-state strobes and a memory request/ready handshake, and detects bus timeouts. It sits between the instruction register and the multi-cycle datapath.

## Interface
- IRQ_EN, 1: 1 = honour `irq` in DECODE; 0 = ignore it.
- EXC_EN, 1: 1 = undefined opcode/funct traps via PCSrc 101; 0 = it executes as NOP (FETCH → DECODE → FETCH).
- MEM_TIMEOUT, 0: max cycles to wait for `mem_ready`; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- irq  in  1  interrupt request (level)
- pc_31  in  1  kernel-mode bit; IRQ is masked when set
- branch_taken  in  1  ALU result bit 0 in EXEC
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access request
- IorD  out  1  0 = instruction address (PC), 1 = data address (ALUOut)
- MemRead, MemWrite  out  1 each
- IRWrite, PCWrite, RegWrite  out  1 each
- RegDst, MemtoReg  out  2 each  same encodings as the single-cycle block (11 = IRQ/exception)
- ALUSrcA  out  2  00 PC, 01 rs, 10 shamt
- ALUSrcB  out  2  00 rt, 01 const 4, 10 ext-imm, 11 ext-imm<<2
- PCSrc  out  3  000 ALU, 001 ALUOut (branch target), 010 jump, 011 rs, 100 IRQ vector, 101 exception vector
- ALUFun  out  6  add 00, sub 01, and 18, or 1E, xor 16, nor 11, sll 20, srl 21, sra 23, eq 33, neq 31, lt 35, lez 3D, gtz 3F, ltz 3B
- ExtOp, LuOp, Sign  out  1 each  same meaning as the single-cycle block
- bus_err  out  1  one-cycle pulse on timeout
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction

## Operation
- State register (3 bits) holds one of: FETCH, DECODE, EXEC, MEM, WB_ALU, WB_MEM, TRAP.
- All outputs are a Moore/Mealy decode of state, opcode, funct and handshake inputs. Unlisted outputs are 0.
- FETCH:
  - Drive mem_req=1, IorD=0, MemRead=1.
  - On mem_ready: IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=01, ALUFun=00, PCSrc=000; go to DECODE. Otherwise stay.
- DECODE:
  - Drive ALUSrcA=00, ALUSrcB=11, ALUFun=00 to precompute the branch target.
  - Priority of the next-state decision: IRQ_EN && irq && !pc_31 → TRAP(IRQ); else if EXC_EN and undefined → TRAP(EXC); else → EXEC.
  - The supported instruction set is the same as the single-cycle decoder.
- EXEC:
  - ALUFun, ExtOp, LuOp, Sign and ALUSrcA/B per instruction.
  - beq/bne/blez/bgtz/bltz: PCWrite=branch_taken, PCSrc=001 → FETCH.
  - j/jal: PCWrite, PCSrc=010 → FETCH. jal also drives RegWrite, RegDst=10, MemtoReg=10.
  - jr/jalr: PCSrc=011 → FETCH. jalr also drives RegWrite, RegDst=10, MemtoReg=10.
  - lw/sw: ALUSrcB=10, ALUFun=00 → MEM.
  - All others → WB_ALU.
- MEM:
  - Drive mem_req, IorD=1, plus MemRead for lw or MemWrite for sw; hold until mem_ready.
  - On mem_ready: lw → WB_MEM, sw → FETCH.
- WB_ALU: RegWrite, MemtoReg=00, RegDst=00 for R-type or 01 for I-type → FETCH.
- WB_MEM: RegWrite, RegDst=01, MemtoReg=01 → FETCH.
- TRAP:
  - RegWrite, RegDst=11, MemtoReg=11, PCWrite.
  - PCSrc=100 for IRQ, 101 for exception or timeout → FETCH.
  - A 1-bit cause register latches the cause on entry.
- Timeout (MEM_TIMEOUT>0):
  - A wait counter, $clog2(MEM_TIMEOUT+1) bits, clears on entry to FETCH or MEM and counts each cycle mem_ready stays low.
  - When it reaches MEM_TIMEOUT with mem_ready still low: pulse bus_err, drop mem_req, go to TRAP(EXC). No IRWrite or writes occur.

## Timing
- Reset:
  - state=FETCH, counter=0, cause=0.
  - While reset is high, all write strobes and mem_req are forced to 0.
  - The first mem_req appears in the first cycle after reset deasserts.
- Reset mid-instruction abandons the instruction with no register or memory write.
- Zero-wait latencies (cycles): branch/j/jr 3, R-type/I-type 4, sw 4, lw 5, TRAP 3.
- Each wait cycle adds 1 in FETCH or MEM.
- mem_req stays high until the cycle mem_ready is seen. Address and read/write strobes are stable throughout.
- irq is sampled only in DECODE. An irq that drops before DECODE is lost.
- instr_done pulses on the cycle the state returns to FETCH. It does not pulse on reset.

## Test plan
- add (opcode 00, funct 20), mem_ready tied high → states F, D, E, WB over 4 cycles; WB cycle has RegWrite=1, RegDst=00, ALUFun=00; instr_done pulses once.
- lw with mem_ready delayed 2 cycles in MEM → 7 cycles total; MemRead and IorD=1 held 3 cycles; WB_MEM has MemtoReg=01.
- beq with branch_taken=1, then with 0 → PCWrite=1 with PCSrc=001 in the first case; PCWrite=0 in EXEC in the second.
- irq=1, pc_31=0 at DECODE of an sw → TRAP with PCSrc=100, RegDst=11; MemWrite is never asserted. Repeat with pc_31=1 → normal sw.
- MEM_TIMEOUT=4, mem_ready held low in FETCH → bus_err pulses 4 cycles after FETCH entry; TRAP follows with PCSrc=101; IRWrite stays 0.
- Reset asserted in the MEM state of an sw → MemWrite=0 that cycle; state=FETCH after the reset cycle.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control: sequences fetch/decode/exec/mem/writeback, drives the
// shared-ALU datapath controls, the memory request/ready handshake and trap redirection.
module multicycle_control #(
   parameter bit          IRQ_EN      = 1'b1,
   parameter bit          EXC_EN      = 1'b1,
   parameter int unsigned MEM_TIMEOUT = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       irq,
   input  logic       pc_31,
   input  logic       branch_taken,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] PCSrc,
   output logic [5:0] ALUFun,
   output logic       ExtOp,
   output logic       LuOp,
   output logic       Sign,
   output logic       bus_err,
   output logic       instr_done
);
   localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   localparam logic [5:0] FUN_ADD = 6'h00, FUN_SUB = 6'h01, FUN_AND = 6'h18,
                          FUN_OR  = 6'h1E, FUN_XOR = 6'h16, FUN_NOR = 6'h11,
                          FUN_SLL = 6'h20, FUN_SRL = 6'h21, FUN_SRA = 6'h23,
                          FUN_EQ  = 6'h33, FUN_NEQ = 6'h31, FUN_LT  = 6'h35,
                          FUN_LEZ = 6'h3D, FUN_GTZ = 6'h3F, FUN_LTZ = 6'h3B;

   typedef enum logic [2:0] {
      FETCH, DECODE, EXEC, MEM, WB_ALU, WB_MEM, TRAP
   } state_e;

   typedef enum logic [3:0] {
      C_UNDEF, C_R, C_I, C_BR, C_J, C_JAL, C_JR, C_JALR, C_LW, C_SW
   } cls_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cause_q, cause_d;   // 0 = IRQ, 1 = exception/timeout

   cls_e       cls;
   logic [5:0] dec_fun;
   logic [1:0] dec_src_a, dec_src_b;
   logic       dec_ext, dec_lu, dec_sign;
   logic       timeout;

   // Instruction class and EXEC-stage ALU controls from the IR fields
   always_comb begin
      cls       = C_UNDEF;
      dec_fun   = FUN_ADD;
      dec_src_a = 2'b01;
      dec_src_b = 2'b00;
      dec_ext   = 1'b0;
      dec_lu    = 1'b0;
      dec_sign  = 1'b0;
      case (opcode)
         6'h00: begin
            cls = C_R;
            case (funct)
               6'h20: dec_sign = 1'b1;
               6'h21: ;
               6'h22: begin dec_fun = FUN_SUB; dec_sign = 1'b1; end
               6'h23: dec_fun = FUN_SUB;
               6'h24: dec_fun = FUN_AND;
               6'h25: dec_fun = FUN_OR;
               6'h26: dec_fun = FUN_XOR;
               6'h27: dec_fun = FUN_NOR;
               6'h00: begin dec_fun = FUN_SLL; dec_src_a = 2'b10; end
               6'h02: begin dec_fun = FUN_SRL; dec_src_a = 2'b10; end
               6'h03: begin dec_fun = FUN_SRA; dec_src_a = 2'b10; end
               6'h2A: begin dec_fun = FUN_LT; dec_sign = 1'b1; end
               6'h2B: dec_fun = FUN_LT;
               6'h08: cls = C_JR;
               6'h09: cls = C_JALR;
               default: cls = C_UNDEF;
            endcase
         end
         6'h23: begin cls = C_LW; dec_src_b = 2'b10; dec_ext = 1'b1; end
         6'h2B: begin cls = C_SW; dec_src_b = 2'b10; dec_ext = 1'b1; end
         6'h0F: begin cls = C_I; dec_src_b = 2'b10; dec_lu = 1'b1; end
         6'h08: begin cls = C_I; dec_src_b = 2'b10; dec_ext = 1'b1; dec_sign = 1'b1; end
         6'h09: begin cls = C_I; dec_src_b = 2'b10; dec_ext = 1'b1; end
         6'h0C: begin cls = C_I; dec_src_b = 2'b10; dec_fun = FUN_AND; end
         6'h0D: begin cls = C_I; dec_src_b = 2'b10; dec_fun = FUN_OR; end
         6'h0A: begin
            cls = C_I; dec_src_b = 2'b10; dec_fun = FUN_LT; dec_ext = 1'b1; dec_sign = 1'b1;
         end
         6'h0B: begin cls = C_I; dec_src_b = 2'b10; dec_fun = FUN_LT; dec_ext = 1'b1; end
         6'h04: begin cls = C_BR; dec_fun = FUN_EQ; end
         6'h05: begin cls = C_BR; dec_fun = FUN_NEQ; end
         6'h06: begin cls = C_BR; dec_fun = FUN_LEZ; end
         6'h07: begin cls = C_BR; dec_fun = FUN_GTZ; end
         6'h01: begin cls = C_BR; dec_fun = FUN_LTZ; end
         6'h02: cls = C_J;
         6'h03: cls = C_JAL;
         default: cls = C_UNDEF;
      endcase
   end

   assign timeout = (MEM_TIMEOUT != 0) && !mem_ready && (cnt_q == CNT_W'(MEM_TIMEOUT));

   // Next state, wait counter, trap cause and all control outputs
   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      cause_d    = cause_q;
      mem_req    = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 2'b00;
      MemtoReg   = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      PCSrc      = 3'b000;
      ALUFun     = FUN_ADD;
      ExtOp      = 1'b0;
      LuOp       = 1'b0;
      Sign       = 1'b0;
      bus_err    = 1'b0;
      instr_done = 1'b0;
      case (state_q)
         FETCH: begin
            mem_req = 1'b1;
            MemRead = 1'b1;
            if (mem_ready) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               ALUSrcB = 2'b01;
               state_d = DECODE;
            end else if (timeout) begin
               mem_req = 1'b0;
               bus_err = 1'b1;
               cause_d = 1'b1;
               state_d = TRAP;
            end
         end
         DECODE: begin
            ALUSrcB = 2'b11;
            if (IRQ_EN && irq && !pc_31) begin
               cause_d = 1'b0;
               state_d = TRAP;
            end else if (EXC_EN && cls == C_UNDEF) begin
               cause_d = 1'b1;
               state_d = TRAP;
            end else if (cls == C_UNDEF) begin
               state_d = FETCH;
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            state_d = FETCH;
            if (cls inside {C_R, C_I, C_BR, C_LW, C_SW}) begin
               ALUSrcA = dec_src_a;
               ALUSrcB = dec_src_b;
               ALUFun  = dec_fun;
               ExtOp   = dec_ext;
               LuOp    = dec_lu;
               Sign    = dec_sign;
            end
            case (cls)
               C_BR: begin PCWrite = branch_taken; PCSrc = 3'b001; end
               C_J, C_JAL: begin PCWrite = 1'b1; PCSrc = 3'b010; end
               C_JR, C_JALR: begin PCWrite = 1'b1; PCSrc = 3'b011; end
               C_LW, C_SW: state_d = MEM;
               default: state_d = WB_ALU;
            endcase
            if (cls == C_JAL || cls == C_JALR) begin
               RegWrite = 1'b1;
               RegDst   = 2'b10;
               MemtoReg = 2'b10;
            end
         end
         MEM: begin
            mem_req  = 1'b1;
            IorD     = 1'b1;
            MemRead  = (cls == C_LW);
            MemWrite = (cls == C_SW);
            if (mem_ready) begin
               state_d = (cls == C_LW) ? WB_MEM : FETCH;
            end else if (timeout) begin
               mem_req  = 1'b0;
               MemWrite = 1'b0;
               bus_err  = 1'b1;
               cause_d  = 1'b1;
               state_d  = TRAP;
            end
         end
         WB_ALU: begin
            RegWrite = 1'b1;
            RegDst   = (cls == C_R) ? 2'b00 : 2'b01;
            state_d  = FETCH;
         end
         WB_MEM: begin
            RegWrite = 1'b1;
            RegDst   = 2'b01;
            MemtoReg = 2'b01;
            state_d  = FETCH;
         end
         TRAP: begin
            RegWrite = 1'b1;
            RegDst   = 2'b11;
            MemtoReg = 2'b11;
            PCWrite  = 1'b1;
            PCSrc    = {2'b10, cause_q};
            state_d  = FETCH;
         end
         default: state_d = FETCH;
      endcase

      if ((state_q == FETCH || state_q == MEM) && state_d == state_q && !mem_ready)
         cnt_d = cnt_q + CNT_W'(1);
      instr_done = (state_d == FETCH) && (state_q != FETCH);

      // Reset abandons the instruction: no side effects on this cycle
      if (reset) begin
         mem_req    = 1'b0;
         MemWrite   = 1'b0;
         IRWrite    = 1'b0;
         PCWrite    = 1'b0;
         RegWrite   = 1'b0;
         bus_err    = 1'b0;
         instr_done = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         cnt_q   <= '0;
         cause_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
      end
   end
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control vectors are queued
// with their stimulus, then replayed and checked mid-cycle.
module tb_multicycle_control;
   typedef struct packed {
      logic       mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, RegWrite;
      logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB;
      logic [2:0] PCSrc;
      logic [5:0] ALUFun;
      logic       ExtOp, LuOp, Sign, bus_err, instr_done;
   } ctl_t;

   typedef struct {
      string      tag;
      ctl_t       exp;
      logic [5:0] op, fn;
      logic       rst, rdy, bt, irq, p31;
   } step_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = 6'h00, funct = 6'h00;
   logic       irq = 1'b0, pc_31 = 1'b0, branch_taken = 1'b0, mem_ready = 1'b0;
   logic       mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, RegWrite;
   logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB;
   logic [2:0] PCSrc;
   logic [5:0] ALUFun;
   logic       ExtOp, LuOp, Sign, bus_err, instr_done;

   ctl_t       obs;
   step_t      sb_q[$];
   logic [5:0] cur_op = 6'h00, cur_fn = 6'h00;
   int         n_cmp = 0, n_fail = 0;

   multicycle_control #(.IRQ_EN(1'b1), .EXC_EN(1'b1), .MEM_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .irq(irq),
      .pc_31(pc_31), .branch_taken(branch_taken), .mem_ready(mem_ready),
      .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
      .ALUFun(ALUFun), .ExtOp(ExtOp), .LuOp(LuOp), .Sign(Sign),
      .bus_err(bus_err), .instr_done(instr_done)
   );

   always #5 clk = ~clk;

   always_comb obs = {mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, RegWrite,
                      RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSrc, ALUFun,
                      ExtOp, LuOp, Sign, bus_err, instr_done};

   function automatic ctl_t f_wait();
      ctl_t c = '0;
      c.mem_req = 1'b1; c.MemRead = 1'b1;
      return c;
   endfunction

   function automatic ctl_t f_go();
      ctl_t c = f_wait();
      c.IRWrite = 1'b1; c.PCWrite = 1'b1; c.ALUSrcB = 2'b01;
      return c;
   endfunction

   function automatic ctl_t dec();
      ctl_t c = '0;
      c.ALUSrcB = 2'b11;
      return c;
   endfunction

   function automatic ctl_t exe(input logic [1:0] a, input logic [1:0] b, input logic [5:0] fun,
                                input logic ext, input logic lu, input logic sgn);
      ctl_t c = '0;
      c.ALUSrcA = a; c.ALUSrcB = b; c.ALUFun = fun;
      c.ExtOp = ext; c.LuOp = lu; c.Sign = sgn;
      return c;
   endfunction

   function automatic ctl_t wb(input logic [1:0] dst, input logic [1:0] mtr);
      ctl_t c = '0;
      c.RegWrite = 1'b1; c.RegDst = dst; c.MemtoReg = mtr; c.instr_done = 1'b1;
      return c;
   endfunction

   function automatic ctl_t mem(input logic is_lw, input logic done);
      ctl_t c = '0;
      c.mem_req = 1'b1; c.IorD = 1'b1; c.MemRead = is_lw; c.MemWrite = !is_lw;
      c.instr_done = done;
      return c;
   endfunction

   function automatic ctl_t trap(input logic [2:0] pcs);
      ctl_t c = '0;
      c.RegWrite = 1'b1; c.RegDst = 2'b11; c.MemtoReg = 2'b11;
      c.PCWrite = 1'b1; c.PCSrc = pcs; c.instr_done = 1'b1;
      return c;
   endfunction

   task automatic push(input string tag, input ctl_t e, input logic rdy_i = 1'b1,
                       input logic bt_i = 1'b0, input logic irq_i = 1'b0,
                       input logic p31_i = 1'b0, input logic rst_i = 1'b0);
      step_t s;
      s.tag = tag; s.exp = e; s.op = cur_op; s.fn = cur_fn;
      s.rst = rst_i; s.rdy = rdy_i; s.bt = bt_i; s.irq = irq_i; s.p31 = p31_i;
      sb_q.push_back(s);
   endtask

   task automatic drain();
      step_t s;
      while (sb_q.size() != 0) begin
         s = sb_q.pop_front();
         @(negedge clk);
         reset = s.rst; mem_ready = s.rdy; branch_taken = s.bt;
         irq = s.irq; pc_31 = s.p31; opcode = s.op; funct = s.fn;
         #1;
         n_cmp++;
         assert (obs === s.exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", s.tag, obs, s.exp);
         end
      end
   endtask

   initial begin
      ctl_t e;

      // reset: only the FETCH read select shows; strobes and mem_req are held off
      e = '0; e.MemRead = 1'b1;
      push("reset0", e, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      push("reset1", e, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drain();

      // add
      cur_op = 6'h00; cur_fn = 6'h20;
      push("add_F", f_go());
      push("add_D", dec());
      push("add_E", exe(2'b01, 2'b00, 6'h00, 1'b0, 1'b0, 1'b1));
      push("add_WB", wb(2'b00, 2'b00));
      drain();

      // addi: I-type writeback to rt
      cur_op = 6'h08; cur_fn = 6'h00;
      push("addi_F", f_go());
      push("addi_D", dec());
      push("addi_E", exe(2'b01, 2'b10, 6'h00, 1'b1, 1'b0, 1'b1));
      push("addi_WB", wb(2'b01, 2'b00));
      drain();

      // lw with two wait cycles in MEM
      cur_op = 6'h23;
      push("lw_F", f_go());
      push("lw_D", dec());
      push("lw_E", exe(2'b01, 2'b10, 6'h00, 1'b1, 1'b0, 1'b0));
      push("lw_M0", mem(1'b1, 1'b0), 1'b0);
      push("lw_M1", mem(1'b1, 1'b0), 1'b0);
      push("lw_M2", mem(1'b1, 1'b0), 1'b1);
      push("lw_WB", wb(2'b01, 2'b01));
      drain();

      // beq taken then not taken
      cur_op = 6'h04;
      push("beqt_F", f_go());
      push("beqt_D", dec());
      e = exe(2'b01, 2'b00, 6'h33, 1'b0, 1'b0, 1'b0);
      e.PCSrc = 3'b001; e.PCWrite = 1'b1; e.instr_done = 1'b1;
      push("beqt_E", e, 1'b1, 1'b1);
      push("beqn_F", f_go());
      push("beqn_D", dec());
      e.PCWrite = 1'b0;
      push("beqn_E", e, 1'b1, 1'b0);
      drain();

      // jal
      cur_op = 6'h03;
      push("jal_F", f_go());
      push("jal_D", dec());
      e = '0; e.PCWrite = 1'b1; e.PCSrc = 3'b010; e.RegWrite = 1'b1;
      e.RegDst = 2'b10; e.MemtoReg = 2'b10; e.instr_done = 1'b1;
      push("jal_E", e);
      drain();

      // sw with irq in user mode traps, no memory write
      cur_op = 6'h2B;
      push("swirq_F", f_go(), 1'b1, 1'b0, 1'b1, 1'b0);
      push("swirq_D", dec(), 1'b1, 1'b0, 1'b1, 1'b0);
      push("swirq_T", trap(3'b100));
      // same with kernel bit set: irq masked, normal sw
      push("swk_F", f_go(), 1'b1, 1'b0, 1'b1, 1'b1);
      push("swk_D", dec(), 1'b1, 1'b0, 1'b1, 1'b1);
      push("swk_E", exe(2'b01, 2'b10, 6'h00, 1'b1, 1'b0, 1'b0));
      push("swk_M", mem(1'b0, 1'b1));
      drain();

      // fetch timeout after 4 low-ready cycles
      for (int i = 0; i < 4; i++) push($sformatf("to_wait%0d", i), f_wait(), 1'b0);
      e = f_wait(); e.mem_req = 1'b0; e.bus_err = 1'b1;
      push("to_err", e, 1'b0);
      push("to_T", trap(3'b101), 1'b0);
      drain();

      // undefined opcode traps to the exception vector
      cur_op = 6'h3F;
      push("undef_F", f_go());
      push("undef_D", dec());
      push("undef_T", trap(3'b101));
      drain();

      // reset during the MEM state of sw
      cur_op = 6'h2B;
      push("rsw_F", f_go());
      push("rsw_D", dec());
      push("rsw_E", exe(2'b01, 2'b10, 6'h00, 1'b1, 1'b0, 1'b0));
      e = '0; e.IorD = 1'b1;
      push("rsw_M_rst", e, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      push("rsw_F_wait", f_wait(), 1'b0);
      push("rsw_F_go", f_go());
      push("rsw_D2", dec());
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
